// File: rtl/tx_ctrl_pkg.sv
// Shared types and defaults for the TX bring-up controller: state encodings,
// the state enum and the default timing/width constants.
package tx_ctrl_pkg;

  localparam int DEF_RST_CYC  = 16;
  localparam int DEF_WARM_CYC = 64;
  localparam int DEF_CNT_W    = 16;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_RST_ALL = 3'd1;
  localparam logic [2:0] ENC_REL_TX  = 3'd2;
  localparam logic [2:0] ENC_WARM    = 3'd3;
  localparam logic [2:0] ENC_RUN     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_RST_ALL = ENC_RST_ALL,
    ST_REL_TX  = ENC_REL_TX,
    ST_WARM    = ENC_WARM,
    ST_RUN     = ENC_RUN
  } tx_state_e;

endpackage

// File: rtl/tx_bringup_ctrl_if.sv
// Control/status bundle between the bring-up controller (slave) and
// whoever sequences it (master).
interface tx_bringup_ctrl_if
  import tx_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] inj_period;
  logic             inj_single;
  logic             rst_tx;
  logic             rst_prbs;
  logic             inj_error;
  logic             ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] inj_count;

  modport master (
    output start, stop, inj_period, inj_single,
    input  rst_tx, rst_prbs, inj_error, ready, state, inj_count
  );

  modport slave (
    input  start, stop, inj_period, inj_single,
    output rst_tx, rst_prbs, inj_error, ready, state, inj_count
  );
endinterface

// File: rtl/tx_ctrl_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module tx_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/tx_bringup_ctrl.sv
// TX bring-up sequencer: staged reset release, warm-up, then RUN with optional
// error injection enabled by defining TX_ERR_INJ_EN.
module tx_bringup_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int WARM_CYC = DEF_WARM_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  tx_bringup_ctrl_if.slave    bus
);

  localparam int MAX_CYC = (RST_CYC > WARM_CYC) ? RST_CYC : WARM_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  tx_state_e        state_q, next_state;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic             rst_tx_q, rst_prbs_q, ready_q;

  tx_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // The timer is loaded with N-1 on each phase entry so the phase lasts N cycles.
  always_comb begin
    next_state = state_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_IDLE: if (bus.start && !bus.stop) begin
        next_state = ST_RST_ALL;
        tmr_load   = 1'b1;
        tmr_val    = TMR_W'(RST_CYC - 1);
      end
      ST_RST_ALL: if (tmr_done) begin
        next_state = ST_REL_TX;
        tmr_load   = 1'b1;
        tmr_val    = TMR_W'(RST_CYC - 1);
      end
      ST_REL_TX: if (tmr_done) begin
        next_state = ST_WARM;
        tmr_load   = 1'b1;
        tmr_val    = TMR_W'(WARM_CYC - 1);
      end
      ST_WARM: if (tmr_done) next_state = ST_RUN;
      ST_RUN:  next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
    if (bus.stop && state_q != ST_IDLE) begin
      next_state = ST_IDLE;
      tmr_load   = 1'b0;
    end
  end

  // Outputs are decoded from next_state so the registered values line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rst_tx_q   <= 1'b1;
      rst_prbs_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= next_state;
      rst_tx_q   <= (next_state inside {ST_IDLE, ST_RST_ALL});
      rst_prbs_q <= (next_state inside {ST_IDLE, ST_RST_ALL, ST_REL_TX});
      ready_q    <= (next_state == ST_RUN);
    end
  end

  assign bus.state    = state_q;
  assign bus.rst_tx   = rst_tx_q;
  assign bus.rst_prbs = rst_prbs_q;
  assign bus.ready    = ready_q;

`ifdef TX_ERR_INJ_EN
  logic [CNT_W-1:0] per_cnt, inj_cnt_q;
  logic             single_q, inj_err_q;
  logic             run_now, per_en, per_hit, per_wrap, single_rise, fire;

  assign run_now     = (state_q == ST_RUN);
  assign per_en      = (bus.inj_period != '0);
  assign per_hit     = run_now && per_en && (per_cnt == bus.inj_period - CNT_W'(1));
  assign per_wrap    = (per_cnt >= bus.inj_period);
  assign single_rise = run_now && bus.inj_single && !single_q;
  assign fire        = (per_hit || single_rise) && (next_state == ST_RUN);

  // A lowered period below the running count wraps silently rather than pulsing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt   <= '0;
      inj_cnt_q <= '0;
      single_q  <= 1'b0;
      inj_err_q <= 1'b0;
    end else begin
      single_q  <= bus.inj_single;
      inj_err_q <= fire;
      if (!run_now) begin
        per_cnt <= '0;
      end else if (per_en) begin
        per_cnt <= (per_hit || per_wrap) ? '0 : per_cnt + CNT_W'(1);
      end
      if (state_q == ST_IDLE && next_state == ST_RST_ALL) begin
        inj_cnt_q <= '0;
      end else if (fire && inj_cnt_q != '1) begin
        inj_cnt_q <= inj_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.inj_error = inj_err_q;
  assign bus.inj_count = inj_cnt_q;
`else
  logic unused_inj_ok;
  assign unused_inj_ok = ^{bus.inj_period, bus.inj_single};
  assign bus.inj_error = 1'b0;
  assign bus.inj_count = '0;
`endif

endmodule
